// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and overflow helpers for the registered ALU.
package alu_pkg;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADC  = 4'b0011;
    localparam logic [3:0] OP_SBC  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_CLRC = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_SHR  = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_NOT  = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Signed overflow from operand and result sign bits only.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sf);
        return (sa == sb) && (sf != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sf);
        return (sa != sb) && (sf != sa);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bundle between the register file, the ALU and the writeback path.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       SSEL;
    logic             OUT_VALID;
    logic [WIDTH-1:0] F;
    logic             Z;
    logic             C;
    logic             S;
    logic             V;

    modport master (
        output IN_VALID, A, B, SSEL,
        input  IN_READY, OUT_VALID, F, Z, C, S, V
    );

    modport slave (
        input  IN_VALID, A, B, SSEL,
        output IN_READY, OUT_VALID, F, Z, C, S, V
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier: one multiplier bit per cycle, product ready WIDTH cycles after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    // r_cnt counts partial products already folded into r_acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(1);
        end else if (r_busy) begin
            if (r_cnt == CW'(WIDTH)) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Bit 0 is folded in at load time so the product is registered by the WIDTH-th cycle.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
            r_mplier <= i_b >> 1;
        end else if (r_busy && (r_cnt != CW'(WIDTH))) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_done = r_busy && (r_cnt == CW'(WIDTH));
    assign o_prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with held Z/C/S/V flags and valid/ready issue handshake.
// Define ALU_MUL_EN to build opcode 1101 as a multi-cycle multiply; otherwise it is reserved.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    alu_seq_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_accept;
    logic             w_single;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_f;
    logic             w_c;
    logic             w_v;

    logic [WIDTH-1:0] r_f;
    logic             r_z;
    logic             r_c;
    logic             r_s;
    logic             r_v;
    logic             r_out_valid;

    assign w_accept = bus.IN_VALID && bus.IN_READY;

`ifdef ALU_MUL_EN
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mul_start  = w_accept && (bus.SSEL == OP_MUL);
    assign w_single     = w_accept && (bus.SSEL != OP_MUL);
    assign bus.IN_READY = !RST && (r_state == ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (CLK),
        .rst     (RST),
        .i_start (w_mul_start),
        .i_a     (bus.A),
        .i_b     (bus.B),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
`else
    assign w_single     = w_accept;
    assign bus.IN_READY = !RST;
`endif

    // Single-cycle datapath: WIDTH+1-bit arithmetic, the top bit is carry or borrow.
    always_comb begin
        w_sum = '0;
        w_f   = '0;
        w_c   = r_c;
        w_v   = r_v;
        case (bus.SSEL)
            OP_PASS: w_f = bus.A;
            OP_INC: begin
                w_sum = {1'b0, bus.A} + {{WIDTH{1'b0}}, 1'b1};
                w_f   = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.A == MAX_POS);
            end
            OP_ADD: begin
                w_sum = {1'b0, bus.A} + {1'b0, bus.B};
                w_f   = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = add_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_ADC: begin
                w_sum = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, r_c};
                w_f   = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = add_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SBC: begin
                w_sum = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, r_c};
                w_f   = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = sub_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum = {1'b0, bus.A} - {1'b0, bus.B};
                w_f   = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = sub_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_DEC: begin
                w_sum = {1'b0, bus.A} - {{WIDTH{1'b0}}, 1'b1};
                w_f   = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.A == MIN_NEG);
            end
            OP_CLRC: begin
                w_f = bus.A;
                w_c = 1'b0;
                w_v = 1'b0;
            end
            OP_AND: begin
                w_f = bus.A & bus.B;
                w_c = 1'b0;
                w_v = 1'b0;
            end
            OP_SHL: begin
                w_f = {bus.A[WIDTH-2:0], 1'b0};
                w_c = bus.A[WIDTH-1];
                w_v = 1'b0;
            end
            OP_OR: begin
                w_f = bus.A | bus.B;
                w_c = 1'b0;
                w_v = 1'b0;
            end
            OP_SHR: begin
                w_f = {1'b0, bus.A[WIDTH-1:1]};
                w_c = bus.A[0];
                w_v = 1'b0;
            end
            OP_XOR: begin
                w_f = bus.A ^ bus.B;
                w_c = 1'b0;
                w_v = 1'b0;
            end
            OP_NOT: begin
                w_f = ~bus.A;
                w_c = 1'b0;
                w_v = 1'b0;
            end
            default: begin
                w_f = '0;
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    // Result/flag register: written by a single-cycle accept or by multiply completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_f         <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_s         <= 1'b0;
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_single) begin
                r_f         <= w_f;
                r_z         <= (w_f == '0);
                r_c         <= w_c;
                r_s         <= w_f[WIDTH-1];
                r_v         <= w_v;
                r_out_valid <= 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (w_mul_done) begin
                r_f         <= w_prod[WIDTH-1:0];
                r_z         <= (w_prod[WIDTH-1:0] == '0);
                r_c         <= 1'b0;
                r_s         <= w_prod[WIDTH-1];
                r_v         <= |w_prod[2*WIDTH-1:WIDTH];
                r_out_valid <= 1'b1;
            end
`endif
        end
    end

    assign bus.OUT_VALID = r_out_valid;
    assign bus.F         = r_f;
    assign bus.Z         = r_z;
    assign bus.C         = r_c;
    assign bus.S         = r_s;
    assign bus.V         = r_v;

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised-width successor to the CPU's combinational 8-bit ALU. It keeps the existing 4-bit SSEL opcode map and adds new operations: carry-in arithmetic, shifts, and an optional multi-cycle multiply. Results and flags are registered, and a held flag register feeds carry-chained operations. It sits between the register file and the writeback path, with a valid/ready handshake on the issue side.

## Interface
- WIDTH, 8: operand and result width in bits (WIDTH ≥ 4).
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  an operation is presented on A, B and SSEL.
- IN_READY  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- SSEL  in  4  opcode.
- OUT_VALID  out  1  one-cycle pulse; F and flags were updated on this cycle's preceding edge.
- F  out  WIDTH  registered result; held between operations.
- Z, C, S, V  out  1 each  registered flags: zero, carry/borrow, sign, signed overflow.

## Operation
- Accept on a rising edge when IN_VALID and IN_READY are both 1. IN_READY = 1 in IDLE, 0 in MUL.
- States:
  - IDLE → IDLE for single-cycle ops.
  - IDLE → MUL on an accepted 1101 (only with ALU_MUL_EN).
  - MUL → IDLE after WIDTH cycles.
- Opcodes (Cin = current C register):
  - 0000 F=A; C and V unchanged.
  - 0001 F=A+1; C=carry-out; V=(A==0111…1).
  - 0010 F=A+B; C=carry-out.
  - 0011 F=A+B+Cin; C=carry-out.
  - 0100 F=A−B−Cin; C=borrow.
  - 0101 F=A−B; C=borrow (1 when A<B unsigned).
  - 0110 F=A−1; C=borrow; V=(A==1000…0).
  - 0111 F=A; C=0, V=0.
  - 1000 F=A&B.
  - 1001 F=A<<1; C=A[WIDTH−1].
  - 1010 F=A|B.
  - 1011 F=A>>1 (logical); C=A[0].
  - 1100 F=A^B.
  - 1101 MUL: F=low WIDTH bits of A×B (unsigned); V=1 iff high half ≠0; C=0.
  - 1110 F=~A.
  - 1111 reserved.
- Add/sub V is signed overflow:
  - Add: operands have equal sign and result sign differs.
  - Sub: operands have different sign and result sign differs from A.
- Logic ops (1000, 1010, 1100, 1110) set C=0, V=0. Shifts set V=0.
- Every completed op sets Z=(F==0) and S=F[WIDTH−1].
- Reserved opcodes (1111, and 1101 without ALU_MUL_EN) complete in one cycle with F=0, C=0, V=0, Z=1, S=0.
- Arithmetic is WIDTH+1 bits internally; the extra bit is the carry/borrow and F is truncated to WIDTH.

## Timing
- Reset values: F=0, Z=0, C=0, S=0, V=0, OUT_VALID=0, state IDLE (IN_READY=1 the cycle after RST falls). While RST=1, inputs are ignored.
- Single-cycle op accepted on edge N: F and flags update on edge N; OUT_VALID=1 for the cycle after N.
- Back-to-back single-cycle ops are accepted on every cycle. OUT_VALID stays high continuously and flags chain: an ADC on edge N+1 uses the C written on edge N.
- MUL accepted on edge N:
  - IN_READY=0 from the cycle after N.
  - F and flags update on edge N+WIDTH, with OUT_VALID=1 for the following cycle.
  - IN_READY returns to 1 in that same cycle.
- A, B and SSEL are sampled only at acceptance. MUL uses internal operand copies, so the inputs may change during MUL.
- IN_VALID while IN_READY=0 is not accepted. The upstream holds the request; the block does not queue it.
- RST during MUL: abort to IDLE, apply reset values, no OUT_VALID.
- No simultaneous accept and MUL completion is possible, because IN_READY=0 during MUL.

## Configuration
- ALU_MUL_EN defined: 1101 is the multi-cycle multiply, with the MUL state and the alu_mul_seq instance present.
- ALU_MUL_EN undefined:
  - 1101 is a reserved opcode.
  - No MUL state; IN_READY is constant 1 outside reset.
  - Every op completes in one cycle.

## Structure
- Package alu_pkg holds:
  - the 4-bit opcode localparams (OP_PASS, OP_INC, OP_ADD, OP_ADC, OP_SBC, OP_SUB, OP_DEC, OP_CLRC, OP_AND, OP_SHL, OP_OR, OP_SHR, OP_XOR, OP_MUL, OP_NOT);
  - the state encoding (ST_IDLE, ST_MUL).
- Sub-module alu_mul_seq (param WIDTH):
  - shift-and-add unsigned multiplier with start/done;
  - 2·WIDTH accumulator, one bit per cycle, done after WIDTH cycles.
- The single-cycle datapath and flag logic stay in alu_seq.

## Test plan
WIDTH=8 throughout.
- Reset: hold RST 2 cycles → F=0x00, ZCSV=0000, OUT_VALID=0; IN_READY=1 on the first cycle after release.
- Signed overflow: ADD 0x7F+0x01 → F=0x80, S=1, V=1, C=0, Z=0. Then SUB 0x00−0x01 → F=0xFF, C=1, S=1, V=0.
- Carry chain: ADD 0xFF+0x01 (F=0x00, Z=1, C=1), then ADC 0x00+0x00 on the next cycle → F=0x01, C=0, Z=0. OUT_VALID is high both cycles.
- Multiply: MUL 0x10×0x11 → IN_READY=0 for 8 cycles; F=0x10, V=1, C=0; OUT_VALID pulses once, 8 edges after accept. Inputs toggled during MUL must have no effect.
- Reset mid-MUL: assert RST on the 4th MUL cycle → no OUT_VALID, reset values, IN_READY=1 after release.
- Shifts and reserved: SHL 0x81 → F=0x02, C=1. SHR 0x01 → F=0x00, C=1, Z=1. SSEL=1111 → F=0x00, Z=1, C=V=S=0. Without ALU_MUL_EN, 1101 gives the same reserved result in one cycle.
